tfe_hash_table_updater: RTL and testbench

Read-modify-write engine that drives the write side of the TFE hash query table. It accepts one packet descriptor at a time (hash index plus timestamp) and reads the table entry. It then computes the new packet count and last-seen time, writes the entry back, and emits a per-packet flow report. It sits between the TFE header/hash stage and the hash query table, and is the only writer of that table.

---
 rtl/tfe_hash_table_updater.sv | 106 ++++++++++
 tb/tb_tfe_hash_table_updater.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tfe_hash_table_updater.sv
// rtl/tfe_hash_table_updater.sv - hash table read-modify-write engine; optional idle timeout via TFE_FLOW_TIMEOUT_EN
module tfe_hash_table_updater #(
    parameter logic [33:0] TIMEOUT = 34'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [15:0] pkt_hash,
    input  logic [33:0] pkt_time,
    output logic [15:0] raddr,
    output logic        read,
    input  logic [4:0]  pkt_cnt,
    input  logic [33:0] last_time,
    input  logic        word_valid,
    input  logic        rdata_valid,
    output logic [15:0] waddr,
    output logic        wea,
    output logic [39:0] wdata,
    output logic        rpt_valid,
    input  logic        rpt_ready,
    output logic [15:0] rpt_hash,
    output logic [4:0]  rpt_cnt,
    output logic        rpt_new
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, UPDATE, REPORT} state_t;

    state_t      state, state_next;
    logic [33:0] time_q;
    logic        accept, capture, restart;
    logic [4:0]  cnt_new;

    assign accept  = (state == IDLE) && pkt_valid && pkt_ready;
    assign capture = (state == WAIT) && rdata_valid;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = WAIT;
            WAIT:    if (rdata_valid) state_next = UPDATE;
            UPDATE:  state_next = REPORT;
            REPORT:  if (rpt_valid && rpt_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The new entry is computed straight from the returning read data so that
    // the write can be registered into the UPDATE cycle.
`ifdef TFE_FLOW_TIMEOUT_EN
    logic [33:0] delta;
    always_comb begin
        delta   = pkt_time_sel() - last_time;
        restart = !word_valid || (delta > TIMEOUT);
    end
    function automatic logic [33:0] pkt_time_sel();
        return time_q;
    endfunction
`else
    always_comb begin
        restart = !word_valid;
    end
`endif

    always_comb begin
        cnt_new = 5'd1;
        if (!restart)
            cnt_new = (pkt_cnt == 5'd31) ? 5'd31 : pkt_cnt + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            time_q    <= '0;
            pkt_ready <= 1'b0;
            raddr     <= '0;
            read      <= 1'b0;
            waddr     <= '0;
            wea       <= 1'b0;
            wdata     <= '0;
            rpt_valid <= 1'b0;
            rpt_hash  <= '0;
            rpt_cnt   <= '0;
            rpt_new   <= 1'b0;
        end else begin
            state     <= state_next;
            pkt_ready <= (state_next == IDLE);
            read      <= (state_next == READ);
            wea       <= (state_next == UPDATE);
            rpt_valid <= (state_next == REPORT);
            if (accept) begin
                raddr  <= pkt_hash;
                time_q <= pkt_time;
            end
            if (capture) begin
                waddr    <= raddr;
                wdata    <= {cnt_new, time_q, 1'b1};
                rpt_hash <= raddr;
                rpt_cnt  <= cnt_new;
                rpt_new  <= restart;
            end
        end
    end

endmodule

// File: tb/tb_tfe_hash_table_updater.sv
// tb/tb_tfe_hash_table_updater.sv - randomized self-checking bench with a table-level reference model
module tb_tfe_hash_table_updater;

    localparam logic [33:0] TIMEOUT_TB = 34'd1000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [15:0] pkt_hash = '0;
    logic [33:0] pkt_time = '0;
    logic [15:0] raddr;
    logic        read;
    logic [4:0]  pkt_cnt = '0;
    logic [33:0] last_time = '0;
    logic        word_valid = 1'b0;
    logic        rdata_valid = 1'b0;
    logic [15:0] waddr;
    logic        wea;
    logic [39:0] wdata;
    logic        rpt_valid;
    logic        rpt_ready = 1'b0;
    logic [15:0] rpt_hash;
    logic [4:0]  rpt_cnt;
    logic        rpt_new;

    int checks = 0;
    int errors = 0;
    time hs_time = 0;

    logic [4:0]  tbl_cnt  [int];
    logic [33:0] tbl_time [int];
    bit          tbl_v    [int];

    always #5 clk = ~clk;

    tfe_hash_table_updater #(.TIMEOUT(TIMEOUT_TB)) dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_hash(pkt_hash), .pkt_time(pkt_time),
        .raddr(raddr), .read(read),
        .pkt_cnt(pkt_cnt), .last_time(last_time), .word_valid(word_valid),
        .rdata_valid(rdata_valid),
        .waddr(waddr), .wea(wea), .wdata(wdata),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_hash(rpt_hash), .rpt_cnt(rpt_cnt), .rpt_new(rpt_new)
    );

    task automatic set_entry(input logic [15:0] h, input logic [4:0] c, input logic [33:0] t, input bit v);
        tbl_cnt[int'(h)]  = c;
        tbl_time[int'(h)] = t;
        tbl_v[int'(h)]    = v;
    endtask

    // One full transaction; the bench plays the table, answering 3 cycles after the read.
    task automatic run_pkt(input logic [15:0] h, input logic [33:0] t, input int hold,
                           input bit keep_valid, input string name);
        logic [4:0]  c_cnt, ecnt;
        logic [33:0] c_time, delta;
        bit          c_v, enew;
        int          waited, last_k;
        waited = 0;
        while (pkt_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (pkt_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: pkt_ready=%b required 1", name, pkt_ready);
            return;
        end
        c_v    = tbl_v.exists(int'(h)) ? tbl_v[int'(h)] : 1'b0;
        c_cnt  = tbl_cnt.exists(int'(h)) ? tbl_cnt[int'(h)] : 5'd0;
        c_time = tbl_time.exists(int'(h)) ? tbl_time[int'(h)] : 34'd0;
        delta  = t - c_time;
        enew   = !c_v;
`ifdef TFE_FLOW_TIMEOUT_EN
        if (c_v && delta > TIMEOUT_TB) enew = 1'b1;
`endif
        ecnt = enew ? 5'd1 : ((c_cnt == 5'd31) ? 5'd31 : c_cnt + 5'd1);

        pkt_valid = 1'b1;
        pkt_hash  = h;
        pkt_time  = t;
        rpt_ready = 1'b0;
        @(posedge clk);
        hs_time = $time;
        last_k = 7 + hold;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            if (!keep_valid || k == last_k) pkt_valid = 1'b0;
            else begin
                pkt_hash = ~h;
                pkt_time = $urandom();
            end
            rdata_valid = (k == 4);
            word_valid  = (k == 4) ? c_v : 1'($urandom());
            pkt_cnt     = (k == 4) ? c_cnt : 5'($urandom());
            last_time   = (k == 4) ? c_time : {2'($urandom()), 32'($urandom())};
            rpt_ready   = (k >= 6 + hold);
            checks++;
            if (read !== (k == 1)) begin
                errors++;
                $display("FAIL %s read k=%0d: got %b required %b", name, k, read, (k == 1));
            end
            checks++;
            if (wea !== (k == 5)) begin
                errors++;
                $display("FAIL %s wea k=%0d: got %b required %b", name, k, wea, (k == 5));
            end
            checks++;
            if (rpt_valid !== (k >= 6 && k <= 6 + hold)) begin
                errors++;
                $display("FAIL %s rpt_valid k=%0d: got %b", name, k, rpt_valid);
            end
            checks++;
            if (pkt_ready !== (k == last_k)) begin
                errors++;
                $display("FAIL %s pkt_ready k=%0d: got %b required %b", name, k, pkt_ready, (k == last_k));
            end
            if (k == 1) begin
                checks++;
                if (raddr !== h) begin
                    errors++;
                    $display("FAIL %s raddr: got %h required %h", name, raddr, h);
                end
            end
            if (k == 5) begin
                checks++;
                if (waddr !== h || wdata !== {ecnt, t, 1'b1}) begin
                    errors++;
                    $display("FAIL %s write: got addr %h data %h required addr %h data %h",
                             name, waddr, wdata, h, {ecnt, t, 1'b1});
                end
            end
            if (k >= 6 && k <= 6 + hold) begin
                checks++;
                if (rpt_hash !== h || rpt_cnt !== ecnt || rpt_new !== enew) begin
                    errors++;
                    $display("FAIL %s report k=%0d: got %h/%0d/%b required %h/%0d/%b",
                             name, k, rpt_hash, rpt_cnt, rpt_new, h, ecnt, enew);
                end
            end
        end
        rpt_ready   = 1'b0;
        rdata_valid = 1'b0;
        set_entry(h, ecnt, t, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pkt_ready, read, raddr, wea, waddr, wdata, rpt_valid, rpt_hash, rpt_cnt, rpt_new} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs, pkt_ready=%b wdata=%h", pkt_ready, wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pkt_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: pkt_ready=%b required 1", pkt_ready);
        end
    endtask

    task automatic test_directed();
        run_pkt(16'h0010, 34'd100, 0, 1'b0, "empty");
        set_entry(16'h0020, 5'd4, 34'd100, 1'b1);
        run_pkt(16'h0020, 34'd200, 0, 1'b0, "repeat");
        set_entry(16'h0030, 5'd31, 34'd500, 1'b1);
        run_pkt(16'h0030, 34'd600, 0, 1'b0, "saturation");
        set_entry(16'h0040, 5'd7, 34'd0, 1'b1);
        run_pkt(16'h0040, 34'd1000001, 0, 1'b0, "timeout");
        set_entry(16'h0041, 5'd7, 34'd0, 1'b1);
        run_pkt(16'h0041, 34'd1000000, 0, 1'b0, "timeout_edge");
        set_entry(16'h0050, 5'd9, 34'h3_FFFF_FFF6, 1'b1);
        run_pkt(16'h0050, 34'd5, 0, 1'b0, "wrap");
    endtask

    task automatic test_backpressure();
        run_pkt(16'h0060, 34'd1234, 5, 1'b0, "backpressure");
        run_pkt(16'h0060, 34'd1300, 2, 1'b1, "valid_while_busy");
    endtask

    task automatic test_back_to_back();
        time t0;
        run_pkt(16'h0070, 34'd10, 0, 1'b0, "b2b_first");
        t0 = hs_time;
        run_pkt(16'h0070, 34'd20, 0, 1'b0, "b2b_second");
        checks++;
        if (hs_time - t0 != 70) begin
            errors++;
            $display("FAIL back_to_back spacing: got %0t required 70", hs_time - t0);
        end
    endtask

    task automatic test_reset_mid();
        run_pkt(16'h0080, 34'd40, 0, 1'b0, "pre_reset");
        pkt_valid = 1'b1;
        pkt_hash  = 16'h0080;
        pkt_time  = 34'd50;
        @(posedge clk);
        @(negedge clk);
        pkt_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pkt_ready, read, raddr, wea, waddr, wdata, rpt_valid, rpt_hash, rpt_cnt, rpt_new} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got wea=%b rpt_valid=%b wdata=%h required all 0", wea, rpt_valid, wdata);
        end
        @(negedge clk);
        rdata_valid = 1'b1;
        word_valid  = 1'b1;
        pkt_cnt     = 5'd3;
        @(negedge clk);
        rdata_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (wea !== 1'b0 || read !== 1'b0 || rpt_valid !== 1'b0 || pkt_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_after k=%0d: wea=%b read=%b rpt_valid=%b pkt_ready=%b required 0/0/0/1",
                         k, wea, read, rpt_valid, pkt_ready);
            end
        end
        run_pkt(16'h0080, 34'd60, 0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        logic [33:0] now;
        logic [15:0] h;
        int          r;
        now = 34'h3_FFFF_F000;
        for (int i = 0; i < 40; i++) begin
            h = 16'h0100 + 16'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0) now = now + 34'd1000001 + 34'($urandom_range(0, 50));
            else if (r == 1) now = now + 34'd1000000;
            else now = now + 34'($urandom_range(1, 3000));
            if ($urandom_range(0, 7) == 0)
                set_entry(h, 5'($urandom_range(25, 31)), now - 34'($urandom_range(0, 100)), 1'($urandom()));
            run_pkt(h, now, $urandom_range(0, 3), 1'($urandom()), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
